// File: rtl/deconv2d_stream_driver.sv
// Host-side sequencer for the deconv2D engine: buffers kernel + tile from a byte stream,
// replays them with the engine's strobe timing, then streams the result RAM out.
module deconv2d_stream_driver #(
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int pixel_bits = 8,
    localparam int CW  = $clog2(K),
    localparam int PW  = $clog2(N*N),
    localparam int AW  = $clog2(N*K*N*K),
    localparam int RW  = 4*pixel_bits
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CW-1:0]         cfg_stride_i,
    input  logic [CW-1:0]         cfg_kernel_width_i,
    output logic                  busy_o,
    output logic                  cfg_err_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [pixel_bits-1:0] in_data_i,
    output logic                  eng_enable_o,
    output logic                  eng_strobe_kernel_o,
    output logic [pixel_bits-1:0] eng_kernel_weight_o,
    output logic                  eng_strobe_pixel_o,
    output logic [pixel_bits-1:0] eng_pixel_o,
    output logic [PW-1:0]         eng_pixel_number_o,
    output logic [CW-1:0]         eng_stride_o,
    output logic [CW-1:0]         eng_kernel_width_o,
    output logic [AW-1:0]         eng_result_address_o,
    input  logic [RW-1:0]         eng_final_output_i,
    input  logic                  eng_done_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [RW-1:0]         out_data_o,
    output logic                  out_last_o
);
    localparam int PER = K*K + 2;
    localparam int KCW = $clog2(K*K + 1);
    localparam int LDW = $clog2(K*K + N*N + 1);
    localparam int TW  = $clog2(PER);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N*K*N*K - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(N*N - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_ENABLE = 4'd2;
    localparam logic [3:0] S_CLR    = 4'd3;
    localparam logic [3:0] S_SENDK  = 4'd4;
    localparam logic [3:0] S_GAP    = 4'd5;
    localparam logic [3:0] S_SENDP  = 4'd6;
    localparam logic [3:0] S_WAITD  = 4'd7;
    localparam logic [3:0] S_READ   = 4'd8;

    logic [3:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [CW-1:0]         stride_q, stride_d;
    logic [CW-1:0]         kw_q, kw_d;
    logic [LDW-1:0]        ld_cnt_q, ld_cnt_d;
    logic [KCW-1:0]        k_cnt_q, k_cnt_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [PW-1:0]         pnum_q, pnum_d;
    logic [pixel_bits-1:0] pix_q, pix_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [RW-1:0]         odata_q, odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  olast_q, olast_d;

    logic [pixel_bits-1:0] kbuf_q [K*K];
    logic [pixel_bits-1:0] pbuf_q [N*N];
    logic                  kbuf_we, pbuf_we;
    logic [KCW-1:0]        kk;
    logic [LDW-1:0]        ld_total;
    logic [KCW-1:0]        k_wr_idx;
    logic [PW-1:0]         p_wr_idx;

    assign kk       = KCW'(kw_q) * KCW'(kw_q);
    assign ld_total = LDW'(kk) + LDW'(N*N);
    assign k_wr_idx = ld_cnt_q[KCW-1:0];
    assign p_wr_idx = PW'(ld_cnt_q - LDW'(kk));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cfg_err_d = 1'b0;
        stride_d  = stride_q;
        kw_d      = kw_q;
        ld_cnt_d  = ld_cnt_q;
        k_cnt_d   = k_cnt_q;
        tmr_d     = tmr_q;
        pnum_d    = pnum_q;
        pix_d     = pix_q;
        addr_d    = addr_q;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        olast_d   = olast_q;
        kbuf_we   = 1'b0;
        pbuf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_kernel_width_i == '0 || int'(cfg_kernel_width_i) > K) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        stride_d = cfg_stride_i;
                        kw_d     = cfg_kernel_width_i;
                        busy_d   = 1'b1;
                        ld_cnt_d = '0;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid_i) begin
                    // first kw*kw words are weights, the rest are pixels
                    if (ld_cnt_q < LDW'(kk)) kbuf_we = 1'b1;
                    else                     pbuf_we = 1'b1;
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == ld_total - 1'b1) state_d = S_ENABLE;
                end
            end
            S_ENABLE: state_d = S_CLR;
            S_CLR: begin
                k_cnt_d = '0;
                state_d = S_SENDK;
            end
            S_SENDK: begin
                k_cnt_d = k_cnt_q + 1'b1;
                if (k_cnt_q == kk - 1'b1) state_d = S_GAP;
            end
            S_GAP: begin
                tmr_d   = '0;
                pnum_d  = '0;
                pix_d   = pbuf_q[0];
                state_d = S_SENDP;
            end
            S_SENDP: begin
                // strobe on tmr==0; pixel/number registers only move at the next period start
                if (tmr_q == '0 && pnum_q == PIX_LAST) begin
                    state_d = S_WAITD;
                end else if (tmr_q == TW'(PER - 1)) begin
                    tmr_d  = '0;
                    pnum_d = pnum_q + 1'b1;
                    pix_d  = pbuf_q[pnum_q + 1'b1];
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAITD: begin
                if (eng_done_i) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!ovalid_q || out_ready_i) begin
                    if (ovalid_q && olast_q) begin
                        ovalid_d = 1'b0;
                        olast_d  = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        odata_d  = eng_final_output_i;
                        ovalid_d = 1'b1;
                        olast_d  = (addr_q == ADDR_LAST);
                        if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            stride_q  <= '0;
            kw_q      <= '0;
            ld_cnt_q  <= '0;
            k_cnt_q   <= '0;
            tmr_q     <= '0;
            pnum_q    <= '0;
            pix_q     <= '0;
            addr_q    <= '0;
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
            stride_q  <= stride_d;
            kw_q      <= kw_d;
            ld_cnt_q  <= ld_cnt_d;
            k_cnt_q   <= k_cnt_d;
            tmr_q     <= tmr_d;
            pnum_q    <= pnum_d;
            pix_q     <= pix_d;
            addr_q    <= addr_d;
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < K*K; i++) kbuf_q[i] <= '0;
            for (int i = 0; i < N*N; i++) pbuf_q[i] <= '0;
        end else begin
            if (kbuf_we) kbuf_q[k_wr_idx] <= in_data_i;
            if (pbuf_we) pbuf_q[p_wr_idx] <= in_data_i;
        end
    end

    assign busy_o               = busy_q;
    assign cfg_err_o            = cfg_err_q;
    assign in_ready_o           = (state_q == S_LOAD);
    assign eng_enable_o         = (state_q == S_ENABLE);
    assign eng_strobe_kernel_o  = (state_q == S_SENDK);
    assign eng_kernel_weight_o  = eng_strobe_kernel_o ? kbuf_q[k_cnt_q] : '0;
    assign eng_strobe_pixel_o   = (state_q == S_SENDP) && (tmr_q == '0);
    assign eng_pixel_o          = pix_q;
    assign eng_pixel_number_o   = pnum_q;
    assign eng_stride_o         = stride_q;
    assign eng_kernel_width_o   = kw_q;
    assign eng_result_address_o = addr_q;
    assign out_valid_o          = ovalid_q;
    assign out_data_o           = odata_q;
    assign out_last_o           = olast_q;

endmodule
